// File: rtl/key_pkg.sv
// Shared constants for the key manager event path: event tag, register map
// and CTRL bit positions.
`default_nettype none

package key_pkg;

  localparam logic [7:0] KEY_EV_TAG       = 8'h01;
  localparam logic [7:0] KEY_RELEASE_CODE = 8'h10;

  localparam logic [1:0] KQ_REG_DATA   = 2'd0;
  localparam logic [1:0] KQ_REG_STATUS = 2'd1;
  localparam logic [1:0] KQ_REG_CTRL   = 2'd2;
  localparam logic [1:0] KQ_REG_COUNT  = 2'd3;

  localparam int KQ_CTRL_IEN   = 0;
  localparam int KQ_CTRL_OVCLR = 1;
  localparam int KQ_CTRL_FLUSH = 2;

  function automatic logic [31:0] kq_status_word(input logic ien, input logic ovf,
                                                 input logic full, input logic empty);
    return {28'b0, ien, ovf, full, empty};
  endfunction

endpackage

`default_nettype wire

// File: rtl/kq_fifo_mem.sv
// Event word storage for key_event_queue: synchronous write, asynchronous
// read, no reset (contents are don't-care until written).
`default_nettype none

module kq_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/key_event_queue.sv
// Key event FIFO between the key manager and the CPU: 4-register slave port,
// sticky overflow, flush, and a level interrupt while unread events exist.
`default_nettype none

module key_event_queue
  import key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_valid,
  input  logic [31:0] ev_data,
  input  logic [1:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        cpu_irq
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d, ien_q, ien_d, irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d, mem_rdata;
  logic          full, empty, ctrl_wr, flush, ovclr, pop, push_ok, ovf_set;
  logic          wdata_unused;

  assign wdata_unused = ^wdata[31:3];

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign ctrl_wr = wr && (addr == KQ_REG_CTRL);
  assign flush   = ctrl_wr && wdata[KQ_CTRL_FLUSH];
  assign ovclr   = ctrl_wr && wdata[KQ_CTRL_OVCLR];
  assign pop     = rd && (addr == KQ_REG_DATA) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted; a flush discards the incoming word without flagging overflow.
  assign push_ok = ev_valid && !flush && (!full || pop);
  assign ovf_set = ev_valid && !flush && full && !pop;

  kq_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (ev_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    ovf_d = (ovf_q && !ovclr) || ovf_set;
    ien_d = ctrl_wr ? wdata[KQ_CTRL_IEN] : ien_q;
    irq_d = ien_d && (count_d != '0);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (addr)
        KQ_REG_DATA:   rdata_d = pop ? mem_rdata : 32'h0;
        KQ_REG_STATUS: rdata_d = kq_status_word(ien_q, ovf_q, full, empty);
        KQ_REG_CTRL:   rdata_d = {31'b0, ien_q};
        default:       rdata_d = {{(32-AW-1){1'b0}}, count_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ien_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ien_q    <= ien_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign cpu_irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue (DEPTH=8).
`default_nettype none

module tb_key_event_queue;
  import key_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic [31:0] ev_data = 32'h0;
  logic [1:0]  addr = 2'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        cpu_irq;

  int checks = 0;
  int failures = 0;

  key_event_queue #(.DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .wdata    (wdata),
    .rdata    (rdata),
    .cpu_irq  (cpu_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d);
    ev_valid = 1'b1; ev_data = d;
    cyc();
    ev_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a);
    rd = 1'b1; addr = a;
    cyc();
    rd = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    wr = 1'b1; addr = KQ_REG_CTRL; wdata = v;
    cyc();
    wr = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    cyc();
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'b0, cpu_irq}, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: status after reset
    rd_reg(KQ_REG_STATUS);
    check("t1_status", rdata, 32'h1);
    check("t1_irq", {31'b0, cpu_irq}, 32'h0);

    // 2: single event with interrupt enabled
    wr_ctrl(32'h1);
    check("t2_irq_before_push", {31'b0, cpu_irq}, 32'h0);
    push(32'h0100_0001);
    check("t2_irq_after_push", {31'b0, cpu_irq}, 32'h1);
    rd_reg(KQ_REG_DATA);
    check("t2_data", rdata, 32'h0100_0001);
    check("t2_irq_after_pop", {31'b0, cpu_irq}, 32'h0);
    rd_reg(KQ_REG_COUNT);
    check("t2_count", rdata, 32'h0);

    // 3: overflow with ien cleared
    wr_ctrl(32'h0);
    ev_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ev_data = 32'h0100_0000 + i;
      cyc();
    end
    ev_valid = 1'b0;
    rd_reg(KQ_REG_STATUS);
    check("t3_status_full_ovf", rdata, 32'h6);
    for (int i = 0; i < 8; i++) begin
      rd_reg(KQ_REG_DATA);
      check($sformatf("t3_data%0d", i), rdata, 32'h0100_0000 + i);
    end
    rd_reg(KQ_REG_DATA);
    check("t3_empty_pop", rdata, 32'h0);
    wr_ctrl(32'h2);
    rd_reg(KQ_REG_STATUS);
    check("t3_ovf_cleared", rdata, 32'h1);

    // 4: push and pop together while full
    for (int i = 0; i < 8; i++) push(32'h0100_0020 + i);
    ev_valid = 1'b1; ev_data = 32'h0100_0010; rd = 1'b1; addr = KQ_REG_DATA;
    cyc();
    ev_valid = 1'b0; rd = 1'b0;
    check("t4_oldest", rdata, 32'h0100_0020);
    rd_reg(KQ_REG_STATUS);
    check("t4_status", rdata, 32'h2);
    rd_reg(KQ_REG_COUNT);
    check("t4_count", rdata, 32'h8);
    for (int i = 1; i < 8; i++) begin
      rd_reg(KQ_REG_DATA);
      check($sformatf("t4_drain%0d", i), rdata, 32'h0100_0020 + i);
    end
    rd_reg(KQ_REG_DATA);
    check("t4_last", rdata, 32'h0100_0010);

    // 5: flush wins over a concurrent push
    for (int i = 0; i < 3; i++) push(32'h0100_0030 + i);
    ev_valid = 1'b1; ev_data = 32'h0100_0040;
    wr = 1'b1; addr = KQ_REG_CTRL; wdata = 32'h5;
    cyc();
    ev_valid = 1'b0; wr = 1'b0;
    check("t5_irq", {31'b0, cpu_irq}, 32'h0);
    rd_reg(KQ_REG_COUNT);
    check("t5_count", rdata, 32'h0);
    rd_reg(KQ_REG_STATUS);
    check("t5_status", rdata, 32'h9);
    rd_reg(KQ_REG_CTRL);
    check("t5_ctrl", rdata, 32'h1);

    // push+pop when empty: no bypass, the word is stored
    ev_valid = 1'b1; ev_data = 32'h0100_0050; rd = 1'b1; addr = KQ_REG_DATA;
    cyc();
    ev_valid = 1'b0; rd = 1'b0;
    check("t5b_no_bypass", rdata, 32'h0);
    check("t5b_irq", {31'b0, cpu_irq}, 32'h1);
    rd_reg(KQ_REG_DATA);
    check("t5b_data", rdata, 32'h0100_0050);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) push({KEY_EV_TAG, 8'h00, KEY_RELEASE_CODE, 8'(i)});
    check("t6_irq_set", {31'b0, cpu_irq}, 32'h1);
    rd_reg(KQ_REG_COUNT);
    check("t6_count_pre", rdata, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("t6_async_rdata", rdata, 32'h0);
    check("t6_async_irq", {31'b0, cpu_irq}, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    rd_reg(KQ_REG_STATUS);
    check("t6_status", rdata, 32'h1);
    rd_reg(KQ_REG_DATA);
    w = rdata;
    check("t6_empty_pop", w, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
